// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin arbitration, one operation in flight, MUL held on the ALU for
// MUL_LATENCY cycles so the multiplier path can be multicycle-constrained.
//
// state | meaning
// IDLE  | no operation in flight; ready offered to the current winner
// EXEC  | latched operands driven onto the ALU, hold counter running down
// RESP  | result held on the granted response channel until it is taken
module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_data0_i,
    input  logic [WIDTH-1:0] req0_data1_i,
    input  logic [2:0]       req0_ctrl_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_data0_i,
    input  logic [WIDTH-1:0] req1_data1_i,
    input  logic [2:0]       req1_ctrl_i,

    output logic             resp0_valid_o,
    input  logic             resp0_ready_i,
    output logic [WIDTH-1:0] resp0_data_o,
    output logic             resp0_zero_o,
    output logic             resp0_err_o,

    output logic             resp1_valid_o,
    input  logic             resp1_ready_i,
    output logic [WIDTH-1:0] resp1_data_o,
    output logic             resp1_zero_o,
    output logic             resp1_err_o,

    output logic [WIDTH-1:0] alu_data0_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,

    output logic             busy_o
);

    localparam logic [2:0] OP_MUL       = 3'b010;
    localparam logic [2:0] OP_LAST      = 3'b100;
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             ptr_q;
    logic             grant_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_ctrl_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_zero_q;
    logic             res_err_q;
    logic             resp0_valid_q;
    logic             resp1_valid_q;
    logic             busy_q;

    logic             win_d;
    logic             accept_d;
    logic             sel_invalid_d;
    logic             resp_take_d;
    logic [WIDTH-1:0] sel_a_d;
    logic [WIDTH-1:0] sel_b_d;
    logic [2:0]       sel_ctrl_d;

    // Winner: a lone requester takes the ALU, a tie goes to the pointer.
    always_comb begin
        win_d = ptr_q;
        if (req0_valid_i && !req1_valid_i) begin
            win_d = 1'b0;
        end else if (req1_valid_i && !req0_valid_i) begin
            win_d = 1'b1;
        end
    end

    // Ready is only raised toward a requester that is asking, and never while
    // reset is held, so a quiet or resetting block shows no ready at all.
    assign req0_ready_o = (state_q == ST_IDLE) && !rst_i && req0_valid_i && !win_d;
    assign req1_ready_o = (state_q == ST_IDLE) && !rst_i && req1_valid_i &&  win_d;
    assign accept_d     = req0_ready_o || req1_ready_o;

    // Operand/op mux from the winning request channel.
    always_comb begin
        sel_a_d    = req0_data0_i;
        sel_b_d    = req0_data1_i;
        sel_ctrl_d = req0_ctrl_i;
        if (win_d) begin
            sel_a_d    = req1_data0_i;
            sel_b_d    = req1_data1_i;
            sel_ctrl_d = req1_ctrl_i;
        end
    end

    assign sel_invalid_d = (sel_ctrl_d > OP_LAST);
    assign resp_take_d   = grant_q ? resp1_ready_i : resp0_ready_i;

    // Sequencer: arbitration, ALU hold window, response hold; all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            grant_q       <= 1'b0;
            cnt_q         <= 4'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= 3'b000;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_err_q     <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        grant_q <= win_d;
                        ptr_q   <= ~win_d;
                        busy_q  <= 1'b1;
                        if (sel_invalid_d) begin
                            // Bad op codes never reach the ALU; answer with err at once.
                            res_data_q    <= '0;
                            res_zero_q    <= 1'b0;
                            res_err_q     <= 1'b1;
                            resp0_valid_q <= ~win_d;
                            resp1_valid_q <= win_d;
                            state_q       <= ST_RESP;
                        end else begin
                            alu_a_q    <= sel_a_d;
                            alu_b_q    <= sel_b_d;
                            alu_ctrl_q <= sel_ctrl_d;
                            cnt_q      <= (sel_ctrl_d == OP_MUL) ? MUL_CNT_INIT : 4'd0;
                            state_q    <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        res_data_q    <= alu_data_i;
                        res_zero_q    <= alu_zero_i;
                        res_err_q     <= 1'b0;
                        alu_a_q       <= '0;
                        alu_b_q       <= '0;
                        alu_ctrl_q    <= 3'b000;
                        resp0_valid_q <= ~grant_q;
                        resp1_valid_q <= grant_q;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_take_d) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp0_valid_o = resp0_valid_q;
    assign resp1_valid_o = resp1_valid_q;
    assign resp0_data_o  = res_data_q;
    assign resp1_data_o  = res_data_q;
    assign resp0_zero_o  = res_zero_q;
    assign resp1_zero_o  = res_zero_q;
    assign resp0_err_o   = res_err_q;
    assign resp1_err_o   = res_err_q;
    assign alu_data0_o   = alu_a_q;
    assign alu_data1_o   = alu_b_q;
    assign alu_ctrl_o    = alu_ctrl_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand sequences for
// contention/backpressure/reset, and a randomized run against a
// transaction-level reference model. A behavioural ALU closes the loop.
module tb_alu_share_arbiter;

    localparam int W  = 32;
    localparam int ML = 3;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req0_valid_i, req1_valid_i;
    logic         req0_ready_o, req1_ready_o;
    logic [W-1:0] req0_data0_i, req0_data1_i, req1_data0_i, req1_data1_i;
    logic [2:0]   req0_ctrl_i, req1_ctrl_i;
    logic         resp0_valid_o, resp1_valid_o;
    logic         resp0_ready_i, resp1_ready_i;
    logic [W-1:0] resp0_data_o, resp1_data_o;
    logic         resp0_zero_o, resp1_zero_o, resp0_err_o, resp1_err_o;
    logic [W-1:0] alu_data0_o, alu_data1_o, alu_data_i;
    logic [2:0]   alu_ctrl_o;
    logic         alu_zero_i;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    alu_share_arbiter #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_data0_i(req0_data0_i), .req0_data1_i(req0_data1_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_data0_i(req1_data0_i), .req1_data1_i(req1_data1_i), .req1_ctrl_i(req1_ctrl_i),
        .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i), .resp0_data_o(resp0_data_o),
        .resp0_zero_o(resp0_zero_o), .resp0_err_o(resp0_err_o),
        .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i), .resp1_data_o(resp1_data_o),
        .resp1_zero_o(resp1_zero_o), .resp1_err_o(resp1_err_o),
        .alu_data0_o(alu_data0_o), .alu_data1_o(alu_data1_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_f(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return p[W-1:0];
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return '0;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] c);
        if (c > 3'd4) return 1;
        if (c == 3'd2) return 1 + ML;
        return 2;
    endfunction

    assign alu_data_i = alu_f(alu_ctrl_o, alu_data0_o, alu_data1_o);
    assign alu_zero_i = (alu_data_i == '0);

    function automatic logic rdy(input int w);    return (w == 1) ? req1_ready_o  : req0_ready_o;  endfunction
    function automatic logic rvalid(input int w); return (w == 1) ? resp1_valid_o : resp0_valid_o; endfunction
    function automatic logic [W-1:0] rdata(input int w); return (w == 1) ? resp1_data_o : resp0_data_o; endfunction
    function automatic logic rzero(input int w);  return (w == 1) ? resp1_zero_o  : resp0_zero_o;  endfunction
    function automatic logic rerr(input int w);   return (w == 1) ? resp1_err_o   : resp0_err_o;   endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int w, input logic v, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        if (w == 0) begin
            req0_valid_i = v; req0_ctrl_i = c; req0_data0_i = a; req0_data1_i = b;
        end else begin
            req1_valid_i = v; req1_ctrl_i = c; req1_data0_i = a; req1_data1_i = b;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set_req(0, 1'b0, 3'd0, '0, '0);
        set_req(1, 1'b0, 3'd0, '0, '0);
        resp0_ready_i = 1'b0;
        resp1_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // One isolated operation: accept, ALU hold window, latency, result, return to idle.
    task automatic run_op(input string nm, input int who, input logic [2:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ed, input logic ez, input logic ee, input int el);
        int   t_acc;
        int   k;
        logic got;
        logic in_exec;
        @(posedge clk_i); #1;
        set_req(who, 1'b1, c, a, b);
        set_req(1 - who, 1'b0, 3'd0, '0, '0);
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        got = 1'b0; t_acc = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (rdy(who)) begin got = 1'b1; t_acc = cyc; end
        end
        chk({nm, "_accept"}, got, 1);
        @(posedge clk_i); #1;
        set_req(who, 1'b0, 3'd0, '0, '0);
        got = 1'b0; k = 0;
        for (int i = 0; i < 24 && !got; i++) begin
            @(negedge clk_i);
            k = cyc - t_acc;
            in_exec = (c <= 3'd4) && (k < el);
            chk({nm, "_alu"}, {alu_ctrl_o, alu_data0_o, alu_data1_o}, in_exec ? {c, a, b} : 67'd0);
            if (rvalid(who)) got = 1'b1;
        end
        chk({nm, "_resp_seen"}, got, 1);
        chk({nm, "_latency"}, k, el);
        chk({nm, "_data"}, rdata(who), ed);
        chk({nm, "_zero"}, rzero(who), ez);
        chk({nm, "_err"}, rerr(who), ee);
        chk({nm, "_other_valid"}, rvalid(1 - who), 0);
        @(negedge clk_i);
        chk({nm, "_idle_after"}, {busy_o, resp0_valid_o, resp1_valid_o}, 0);
    endtask

    typedef struct {
        int           who;
        logic [2:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ed;
        logic         ez;
        logic         ee;
        int           el;
    } vec_t;

    vec_t vt[11];

    // reference-model state for the randomized run
    logic         m_busy, m_ptr, m_gnt;
    int           m_acc, m_lat;
    logic [2:0]   m_ctrl;
    logic [W-1:0] m_a, m_b;
    logic         pend0, pend1, acc0, acc1;
    logic [2:0]   p0_c, p1_c;
    logic [W-1:0] p0_a, p0_b, p1_a, p1_b;

    task automatic gen_op(output logic [2:0] c, output logic [W-1:0] a, output logic [W-1:0] b);
        c = 3'($urandom_range(0, 7));
        a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           ord[4];
        int           acc_cyc[4];
        int           nacc;
        int           hits;
        int           k;
        logic         v0, v1, w, er0, er1, erv, in_exec;
        logic [W-1:0] ed;

        vt[0]  = '{0, 3'd0, 32'd7,          32'd5,          32'd12,         1'b0, 1'b0, 2};
        vt[1]  = '{1, 3'd1, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 2};
        vt[2]  = '{1, 3'd2, 32'd6,          32'd7,          32'd42,         1'b0, 1'b0, 4};
        vt[3]  = '{0, 3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0, 1'b0, 4};
        vt[4]  = '{0, 3'd3, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b0, 2};
        vt[5]  = '{1, 3'd4, 32'd1,          32'd2,          32'd3,          1'b0, 1'b0, 2};
        vt[6]  = '{0, 3'd7, 32'd3,          32'd4,          32'd0,          1'b0, 1'b1, 1};
        vt[7]  = '{1, 3'd5, 32'd8,          32'd8,          32'd0,          1'b0, 1'b1, 1};
        vt[8]  = '{0, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 2};
        vt[9]  = '{1, 3'd1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 2};
        vt[10] = '{0, 3'd2, 32'd0,          32'd12345,      32'd0,          1'b1, 1'b0, 4};

        // reset state, with both requesters asking during reset
        rst_i = 1'b1;
        set_req(0, 1'b1, 3'd0, 32'd1, 32'd2);
        set_req(1, 1'b1, 3'd2, 32'd3, 32'd4);
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        @(negedge clk_i);
        chk("reset_ctl", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, resp0_zero_o,
                          resp1_zero_o, resp0_err_o, resp1_err_o, busy_o, alu_ctrl_o}, 0);
        chk("reset_data", resp0_data_o | resp1_data_o | alu_data0_o | alu_data1_o, 0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].who, vt[i].c, vt[i].a, vt[i].b,
                   vt[i].ed, vt[i].ez, vt[i].ee, vt[i].el);
        end

        // contention: both SUB 9,9 from reset, grant order 0,1,0,1 at one op per 3 cycles
        rst_i = 1'b1;
        set_req(0, 1'b1, 3'd1, 32'd9, 32'd9);
        set_req(1, 1'b1, 3'd1, 32'd9, 32'd9);
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        nacc = 0;
        for (int i = 0; i < 4; i++) begin ord[i] = -1; acc_cyc[i] = 0; end
        for (int i = 0; i < 40 && nacc < 4; i++) begin
            @(negedge clk_i);
            if (resp0_valid_o) chk("cont_resp0", {resp0_data_o, resp0_zero_o, resp0_err_o}, {32'd0, 1'b1, 1'b0});
            if (resp1_valid_o) chk("cont_resp1", {resp1_data_o, resp1_zero_o, resp1_err_o}, {32'd0, 1'b1, 1'b0});
            if (req0_ready_o && nacc < 4) begin ord[nacc] = 0; acc_cyc[nacc] = cyc; nacc++; end
            if (req1_ready_o && nacc < 4) begin ord[nacc] = 1; acc_cyc[nacc] = cyc; nacc++; end
        end
        chk("cont_count", nacc, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), ord[i], i % 2);
        for (int i = 1; i < 4; i++) chk($sformatf("cont_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
        do_reset();

        // backpressure: resp0 held 5+ cycles, req1 blocked until one cycle after handshake
        @(posedge clk_i); #1;
        set_req(0, 1'b1, 3'd0, 32'd1, 32'd1);
        resp0_ready_i = 1'b0;
        @(negedge clk_i);
        chk("bp_accept0", req0_ready_o, 1);
        @(posedge clk_i); #1;
        set_req(0, 1'b0, 3'd0, '0, '0);
        set_req(1, 1'b1, 3'd0, 32'd2, 32'd3);
        resp1_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_exec_ready1", req1_ready_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk($sformatf("bp_hold%0d", i), {resp0_valid_o, resp0_data_o, resp1_valid_o, req1_ready_o},
                {1'b1, 32'd2, 1'b0, 1'b0});
        end
        @(posedge clk_i); #1 resp0_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_handshake", {resp0_valid_o, req1_ready_o}, 2'b10);
        @(posedge clk_i); #1 resp0_ready_i = 1'b0;
        @(negedge clk_i);
        chk("bp_accept1", {resp0_valid_o, req1_ready_o}, 2'b01);
        @(posedge clk_i); #1 set_req(1, 1'b0, 3'd0, '0, '0);
        hits = 0;
        for (int i = 0; i < 10 && hits == 0; i++) begin
            @(negedge clk_i);
            if (resp1_valid_o) begin hits = 1; chk("bp_resp1_data", resp1_data_o, 5); end
        end
        chk("bp_resp1_seen", hits, 1);
        do_reset();

        // reset in the 2nd EXEC cycle of a MUL: outputs clear at once, nothing re-issued, pointer 0
        @(posedge clk_i); #1;
        set_req(1, 1'b1, 3'd2, 32'd6, 32'd7);
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mul_accept", req1_ready_o, 1);
        @(posedge clk_i); #1 set_req(1, 1'b0, 3'd0, '0, '0);
        @(posedge clk_i); #1;
        chk("rst_exec2_alu", {alu_ctrl_o, alu_data0_o, alu_data1_o}, {3'd2, 32'd6, 32'd7});
        rst_i = 1'b1;
        set_req(0, 1'b1, 3'd0, 32'd1, 32'd1);
        set_req(1, 1'b1, 3'd0, 32'd1, 32'd1);
        #1;
        chk("rst_async_ctl", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o, alu_ctrl_o,
                              resp0_err_o, resp0_zero_o}, 0);
        chk("rst_async_data", alu_data0_o | alu_data1_o | resp1_data_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ptr_winner", {req0_ready_o, req1_ready_o}, 2'b10);
        @(posedge clk_i); #1;
        set_req(0, 1'b0, 3'd0, '0, '0);
        set_req(1, 1'b0, 3'd0, '0, '0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (resp1_valid_o) hits++;
        end
        chk("rst_no_reissue", hits, 0);
        do_reset();

        // randomized run against the transaction-level model
        m_busy = 1'b0; m_ptr = 1'b0; m_gnt = 1'b0; m_acc = 0; m_lat = 0;
        m_ctrl = 3'd0; m_a = '0; m_b = '0;
        pend0 = 1'b0; pend1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        p0_c = 3'd0; p1_c = 3'd0; p0_a = '0; p0_b = '0; p1_a = '0; p1_b = '0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk_i); #1;
            if (acc0) pend0 = 1'b0;
            if (acc1) pend1 = 1'b0;
            if (!pend0 && $urandom_range(0, 2) == 0) begin pend0 = 1'b1; gen_op(p0_c, p0_a, p0_b); end
            if (!pend1 && $urandom_range(0, 2) == 0) begin pend1 = 1'b1; gen_op(p1_c, p1_a, p1_b); end
            set_req(0, pend0, p0_c, p0_a, p0_b);
            set_req(1, pend1, p1_c, p1_a, p1_b);
            resp0_ready_i = ($urandom_range(0, 3) != 0);
            resp1_ready_i = ($urandom_range(0, 3) != 0);
            acc0 = 1'b0; acc1 = 1'b0;
            @(negedge clk_i);
            v0  = pend0;
            v1  = pend1;
            w   = (v0 && !v1) ? 1'b0 : ((v1 && !v0) ? 1'b1 : m_ptr);
            er0 = !m_busy && v0 && !w;
            er1 = !m_busy && v1 && w;
            chk("rnd_ready", {req0_ready_o, req1_ready_o}, {er0, er1});
            k   = cyc - m_acc;
            erv = m_busy && (k >= m_lat);
            chk("rnd_resp_valid", {resp0_valid_o, resp1_valid_o}, {erv && !m_gnt, erv && m_gnt});
            if (erv) begin
                ed = (m_ctrl > 3'd4) ? '0 : alu_f(m_ctrl, m_a, m_b);
                chk("rnd_resp", {rdata(m_gnt), rzero(m_gnt), rerr(m_gnt)},
                    {ed, (m_ctrl <= 3'd4) && (ed == '0), m_ctrl > 3'd4});
            end
            chk("rnd_busy", busy_o, m_busy);
            in_exec = m_busy && (m_ctrl <= 3'd4) && (k >= 1) && (k < m_lat);
            chk("rnd_alu", {alu_ctrl_o, alu_data0_o, alu_data1_o}, in_exec ? {m_ctrl, m_a, m_b} : 67'd0);
            if (erv && (m_gnt ? resp1_ready_i : resp0_ready_i)) begin
                m_busy = 1'b0;
            end else if (er0 || er1) begin
                m_busy = 1'b1;
                m_gnt  = w;
                m_ptr  = ~w;
                m_acc  = cyc;
                m_ctrl = w ? p1_c : p0_c;
                m_a    = w ? p1_a : p0_a;
                m_b    = w ? p1_b : p0_b;
                m_lat  = lat_of(m_ctrl);
                if (w) acc1 = 1'b1; else acc0 = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
